rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 The block SHALL take parameter QUANTUM, default 8, meaning the maximum consecutive grant cycles while another requester waits (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  8  request per requester, level, held until served.
REQ-005 The block SHALL have port grant  output  8  registered one-hot grant, all-zero when idle.
REQ-006 The block SHALL have port grant_idx  output  3  binary index of the set grant bit, 3'd0 when idle.
REQ-007 The block SHALL have port grant_valid  output  1  high exactly when grant is non-zero.

Function
REQ-008 The block SHALL implement two states: IDLE (no grant) and GRANT (one grant held).
REQ-009 The block SHALL keep a 3-bit priority pointer ptr; search order is ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-010 In IDLE with req != 0 at a clock edge, the block SHALL enter GRANT and set grant to the first req bit in search order (latency 1 cycle from sampled req).
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs at reset values.
REQ-012 grant_idx and grant_valid SHALL update on the same edge as grant and always be consistent with it; grant SHALL never have more than one bit set.
REQ-013 An 8-bit hold counter SHALL clear to 0 on entry to GRANT and increment each GRANT cycle, saturating at QUANTUM-1.
REQ-014 In GRANT, if req[grant_idx] is sampled low, the block SHALL release: next edge grant=0, grant_valid=0, grant_idx=0, state IDLE.
REQ-015 In GRANT, if counter == QUANTUM-1 and (req & ~grant) != 0, the block SHALL force a release as in REQ-014, even with req[grant_idx] still high.
REQ-016 With counter saturated and no other requester, the grant SHALL be held indefinitely; a later competing req forces release on the next edge.
REQ-017 On every release, ptr SHALL become grant_idx+1 with 3-bit wrap (7 -> 0); ptr SHALL not change otherwise.
REQ-018 Every release SHALL be followed by at least one IDLE cycle (one-cycle grant gap) before the next grant.
REQ-019 Simultaneous release condition and new requests SHALL resolve as release first; the new arbitration uses the updated ptr in the following IDLE cycle.
REQ-020 Requests raised or dropped by non-granted requesters during GRANT SHALL have no effect except on the REQ-015 check.
REQ-021 Worst-case wait for a continuously asserted request SHALL be 7*(QUANTUM+1) cycles.

Reset
REQ-022 When rst is high at a clock edge, the block SHALL set state=IDLE, ptr=0, counter=0, grant=8'h00, grant_idx=3'd0, grant_valid=0, regardless of req.
REQ-023 rst asserted mid-grant SHALL drop the grant on that edge with no release bookkeeping (ptr forced to 0).
REQ-024 The first arbitration after rst deasserts SHALL use ptr=0 (requester 0 highest priority).

Verification
REQ-025 After reset, req=8'b00000101 -> next cycle grant=8'b00000001, grant_idx=0; drop req[0] -> one cycle grant=0, then grant=8'b00000100, grant_idx=2.
REQ-026 QUANTUM=8, req=8'hFF held -> grants rotate idx 0,1,...,7,0, each held exactly 8 cycles, separated by one idle cycle.
REQ-027 req=8'h80 alone for 20 cycles -> grant=8'h80, grant_idx=7 held all cycles after the first; drop req -> release, ptr=0 (verify by req=8'h81 -> grant idx 0).
REQ-028 During grant to idx 3, assert rst one cycle -> next edge grant=0, grant_valid=0; then req=8'h18 -> grant idx 3 (ptr reset to 0).
REQ-029 One-cycle req pulse 8'h02 in IDLE -> grant=8'h02 for exactly one cycle, then release, ptr=2.
REQ-030 Random req stream for 10k cycles -> checker confirms one-hot grant, grant_idx/grant_valid consistency, REQ-018 gap, and REQ-021 wait bound.

Source files
------------

// File: rtl/rr_arb8.sv
// rr_arb8 -- 8-way round-robin arbiter with a per-grant hold quantum.
//
// A grant is kept while its requester holds req. If it has been held for
// QUANTUM cycles and another requester is waiting, it is released. Every
// release is followed by one idle cycle before the next grant. On release
// the priority pointer moves to the slot just after the released requester.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req[7:0]    level request per requester, held until served
//   grant[7:0]  registered one-hot grant, zero when idle
//   grant_idx   binary index of the granted requester, 0 when idle
//   grant_valid high exactly when grant is non-zero
module rr_arb8 #(
  parameter int QUANTUM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] CNT_MAX = 8'(QUANTUM - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] cnt;

  logic [2:0] pick_idx;
  logic       pick_any;
  logic [2:0] cand;
  logic       release_now;

  // First requester in the order ptr, ptr+1, ... (3-bit wrap).
  always_comb begin
    pick_idx = 3'd0;
    pick_any = 1'b0;
    cand     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!pick_any && req[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Release when the owner drops its request, or when the quantum is used
  // up and someone else is waiting. The counter saturates, so a lone owner
  // keeps the grant until a competitor appears.
  always_comb begin
    release_now = !req[grant_idx] ||
                  ((cnt == CNT_MAX) && ((req & ~grant) != 8'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= 8'd0;
      grant       <= 8'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state       <= GRANT;
            grant       <= 8'd1 << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            cnt         <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Always return to IDLE first: this is the one-cycle grant gap,
            // and the next arbitration sees the advanced pointer.
            state       <= IDLE;
            grant       <= 8'd0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 3'd1;
            cnt         <= 8'd0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8.sv
module tb_rr_arb8;

  localparam int Q     = 8;
  localparam int BOUND = 7 * (Q + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;

  rr_arb8 #(.QUANTUM(Q)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: who owns the grant, for how many cycles so far,
  // and where the next search begins.
  bit         m_busy = 1'b0;
  int         m_idx  = 0;
  int         m_ptr  = 0;
  int         m_held = 0;
  logic [7:0] req_s  = 8'd0;

  always @(posedge clk) begin
    bit         found;
    logic [7:0] others;
    req_s = req;
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (!found && req[(m_ptr + j) % 8]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_idx  = (m_ptr + j) % 8;
          m_held = 1;
        end
      end
    end else begin
      others = req & ~(8'd1 << m_idx);
      if (!req[m_idx] || (m_held >= Q && others != 8'd0)) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 8;
        m_idx  = 0;
      end else begin
        m_held++;
      end
    end
  end

  // Per-cycle comparison against the model plus structural invariants on
  // the DUT outputs (one-hot, consistency, idle gap, wait bound).
  logic [7:0] prev_grant = 8'd0;
  int         dwait[8];
  initial for (int i = 0; i < 8; i++) dwait[i] = 0;

  always @(negedge clk) begin
    logic [7:0] e_grant;
    if (started) begin
      e_grant = m_busy ? (8'd1 << m_idx) : 8'd0;
      chk("grant", 32'(grant), 32'(e_grant));
      chk("grant_idx", 32'(grant_idx), 32'(m_busy ? m_idx : 0));
      chk("grant_valid", 32'(grant_valid), 32'(m_busy));
      chk("onehot", 32'($countones(grant) <= 1), 32'd1);
      chk("valid_consistent", 32'(grant_valid), 32'(grant != 8'd0));
      if (grant != 8'd0) chk("idx_consistent", 32'(grant[grant_idx]), 32'd1);
      else               chk("idx_idle_zero", 32'(grant_idx), 32'd0);
      if (prev_grant != 8'd0 && grant != 8'd0)
        chk("grant_gap", 32'(grant), 32'(prev_grant));
      for (int i = 0; i < 8; i++) begin
        if (grant[i] && !prev_grant[i]) begin
          chk("wait_bound", 32'(dwait[i] <= BOUND), 32'd1);
          dwait[i] = 0;
        end else if (req_s[i] && !grant[i] && !prev_grant[i]) begin
          dwait[i]++;
        end else if (!req_s[i]) begin
          dwait[i] = 0;
        end
      end
      prev_grant = grant;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_g(input string name, input logic [7:0] g, input logic [2:0] idx);
    chk({name, "_grant"}, 32'(grant), 32'(g));
    chk({name, "_idx"}, 32'(grant_idx), 32'(idx));
    chk({name, "_valid"}, 32'(grant_valid), 32'(g != 8'd0));
  endtask

  initial begin
    rst = 1'b1; req = 8'd0;
    step(2);
    rst = 1'b0;
    started = 1'b1;
    expect_g("reset", 8'h00, 3'd0);
    step(1);
    expect_g("idle_noreq", 8'h00, 3'd0);

    // Two requesters, ptr=0: 0 first, then 2 after a one-cycle gap.
    req = 8'h05; step(1);
    expect_g("r025_first", 8'h01, 3'd0);
    req = 8'h04; step(1);
    expect_g("r025_gap", 8'h00, 3'd0);
    step(1);
    expect_g("r025_second", 8'h04, 3'd2);
    req = 8'h00; step(2);

    // One-cycle pulse: one grant cycle, then ptr=2 so bit 0 beats bit 1.
    req = 8'h02; step(1);
    expect_g("pulse_grant", 8'h02, 3'd1);
    req = 8'h00; step(1);
    expect_g("pulse_release", 8'h00, 3'd0);
    req = 8'h03; step(1);
    expect_g("pulse_ptr2", 8'h01, 3'd0);
    req = 8'h00; step(2);

    // All requesting: rotation 0..7,0 with QUANTUM-cycle holds and gaps.
    rst = 1'b1; step(1); rst = 1'b0;
    req = 8'hFF; step(1);
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < Q; c++) begin
        expect_g("rotate_hold", 8'd1 << (k % 8), 3'(k % 8));
        step(1);
      end
      expect_g("rotate_gap", 8'h00, 3'd0);
      if (k == 8) req = 8'h00;
      step(1);
    end

    // Lone requester 7 holds past the quantum; release wraps ptr to 0.
    req = 8'h80; step(1);
    for (int c = 0; c < 20; c++) begin
      expect_g("lone7", 8'h80, 3'd7);
      step(1);
    end
    req = 8'h00; step(1);
    expect_g("lone7_release", 8'h00, 3'd0);
    req = 8'h81; step(1);
    expect_g("ptr_wrap0", 8'h01, 3'd0);
    req = 8'h00; step(2);

    // Reset mid-grant drops the grant and returns ptr to 0.
    req = 8'h08; step(1);
    expect_g("pre_rst", 8'h08, 3'd3);
    step(2);
    rst = 1'b1; step(1);
    expect_g("mid_rst", 8'h00, 3'd0);
    rst = 1'b0; req = 8'h18; step(1);
    expect_g("post_rst", 8'h08, 3'd3);
    req = 8'h00; step(2);

    // Saturated hold is broken by a late competitor on the next edge.
    req = 8'h20; step(1);
    expect_g("sat_first", 8'h20, 3'd5);
    step(14);
    expect_g("sat_hold", 8'h20, 3'd5);
    req = 8'h21; step(1);
    expect_g("sat_forced", 8'h00, 3'd0);
    step(1);
    expect_g("sat_next", 8'h01, 3'd0);
    req = 8'h00; step(2);

    // Random stream: requests stay up until served, owners drop at random.
    rst = 1'b1; step(1); rst = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          if (m_busy && m_idx == i && $urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b1;
        end
      end
      step(1);
    end
    req = 8'h00; step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
